// File: rtl/adc_pulse_sim_pkg.sv
// adc_pulse_sim_pkg: sequencer state encoding, sample limits and saturating sample add
package adc_pulse_sim_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PULSE_A = 3'd1,
      GAP_AB  = 3'd2,
      PULSE_B = 3'd3,
      GAP_BC  = 3'd4,
      PULSE_C = 3'd5,
      FINISH  = 3'd6
   } state_t;

   localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
   localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

   // 17-bit sum: the top two bits disagree only when the 16-bit result overflowed
   function automatic logic [15:0] sat16(input logic signed [15:0] a, input logic signed [15:0] b);
      logic [16:0] s;
      s = {a[15], a} + {b[15], b};
      return (s[16:15] == 2'b01) ? SAMPLE_MAX : (s[16:15] == 2'b10) ? SAMPLE_MIN : s[15:0];
   endfunction

endpackage

// File: rtl/adc_word_sat.sv
// adc_word_sat: paired-sample word, either the saturated pulse level or the baseline
module adc_word_sat
   import adc_pulse_sim_pkg::*;
(
   input  logic [15:0] baseline,
   input  logic [15:0] amp,
   input  logic        pulse_en,
   output logic [31:0] word
);

   always_comb word = pulse_en ? {2{sat16(baseline, amp)}} : {2{baseline}};

endmodule

// File: rtl/adc_pulse_sim.sv
// adc_pulse_sim: synthetic four-channel ADC source emitting a timed A/B/C rectangular pulse train
module adc_pulse_sim
   import adc_pulse_sim_pkg::*;
#(
   parameter int ADC_DATA_WIDTH = 16,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                        rxclk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [ADC_DATA_WIDTH-1:0]   baseline,
   input  logic [ADC_DATA_WIDTH-1:0]   amp_a,
   input  logic [ADC_DATA_WIDTH-1:0]   amp_b,
   input  logic [ADC_DATA_WIDTH-1:0]   amp_c,
   input  logic [15:0]                 pulse_width,
   input  logic [CNT_WIDTH-1:0]        delay_ab,
   input  logic [CNT_WIDTH-1:0]        delay_bc,
   output logic [2*ADC_DATA_WIDTH-1:0] adc_data_a,
   output logic [2*ADC_DATA_WIDTH-1:0] adc_data_b,
   output logic [2*ADC_DATA_WIDTH-1:0] adc_data_c,
   output logic [2*ADC_DATA_WIDTH-1:0] adc_data_d,
   output logic                        adc_valid_a,
   output logic                        adc_valid_b,
   output logic                        adc_valid_c,
   output logic                        adc_valid_d,
   output logic                        adc_enable_a,
   output logic                        adc_enable_b,
   output logic                        adc_enable_c,
   output logic                        adc_enable_d,
   output logic                        busy,
   output logic                        done
);

   state_t state, nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_n, dab_q, dbc_q, pw_ld;
   logic [15:0] pw_q, pw_m1;
   logic [ADC_DATA_WIDTH-1:0] base_q, amp_a_q, amp_b_q, amp_c_q;
   logic [ADC_DATA_WIDTH-1:0] base_src, amp_a_src, amp_b_src, amp_c_src;
   logic [2*ADC_DATA_WIDTH-1:0] word_a, word_b, word_c;
   logic idle;

   assign idle  = state == IDLE;
   assign pw_m1 = (pulse_width == '0) ? '0 : pulse_width - 1'b1;
   assign pw_ld = CNT_WIDTH'(pw_q);

   always_ff @(posedge rxclk)
      if (rst) state <= IDLE;
      else state <= nxt;

   // counter holds the clocks remaining in the current state minus one
   always_comb begin
      nxt   = state;
      cnt_n = cnt - 1'b1;
      case (state)
         IDLE: begin
            cnt_n = start ? CNT_WIDTH'(pw_m1) : '0;
            nxt   = start ? PULSE_A : IDLE;
         end
         PULSE_A: if (cnt == '0) begin
            nxt   = (dab_q != '0) ? GAP_AB : PULSE_B;
            cnt_n = (dab_q != '0) ? dab_q - 1'b1 : pw_ld;
         end
         GAP_AB: if (cnt == '0) begin
            nxt   = PULSE_B;
            cnt_n = pw_ld;
         end
         PULSE_B: if (cnt == '0) begin
            nxt   = (dbc_q != '0) ? GAP_BC : PULSE_C;
            cnt_n = (dbc_q != '0) ? dbc_q - 1'b1 : pw_ld;
         end
         GAP_BC: if (cnt == '0) begin
            nxt   = PULSE_C;
            cnt_n = pw_ld;
         end
         PULSE_C: if (cnt == '0) begin
            nxt   = FINISH;
            cnt_n = '0;
         end
         default: begin
            nxt   = IDLE;
            cnt_n = '0;
         end
      endcase
   end

   // outputs are registered from the next state, so values come from the live inputs while idle
   assign base_src  = (idle || nxt == IDLE) ? baseline : base_q;
   assign amp_a_src = idle ? amp_a : amp_a_q;
   assign amp_b_src = idle ? amp_b : amp_b_q;
   assign amp_c_src = idle ? amp_c : amp_c_q;

   adc_word_sat u_sat_a (.baseline(base_src), .amp(amp_a_src), .pulse_en(nxt == PULSE_A), .word(word_a));
   adc_word_sat u_sat_b (.baseline(base_src), .amp(amp_b_src), .pulse_en(nxt == PULSE_B), .word(word_b));
   adc_word_sat u_sat_c (.baseline(base_src), .amp(amp_c_src), .pulse_en(nxt == PULSE_C), .word(word_c));

   always_ff @(posedge rxclk)
      if (rst) begin
         cnt <= '0;
         {dab_q, dbc_q, pw_q} <= '0;
         {base_q, amp_a_q, amp_b_q, amp_c_q} <= '0;
         {adc_data_a, adc_data_b, adc_data_c, adc_data_d} <= '0;
         {adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d} <= '0;
         {adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d} <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         cnt <= cnt_n;
         if (idle && start) begin
            {dab_q, dbc_q, pw_q} <= {delay_ab, delay_bc, pw_m1};
            {base_q, amp_a_q, amp_b_q, amp_c_q} <= {baseline, amp_a, amp_b, amp_c};
         end
         adc_data_a <= word_a;
         adc_data_b <= word_b;
         adc_data_c <= word_c;
         adc_data_d <= {2{base_src}};
         {adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d} <= '1;
         {adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d} <= '1;
         busy <= nxt != IDLE && nxt != FINISH;
         done <= nxt == FINISH;
      end

endmodule

// File: tb/tb_adc_pulse_sim.sv
// tb_adc_pulse_sim: scoreboard bench comparing the pulse source against a timeline model
module tb_adc_pulse_sim;

   logic rxclk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [15:0] baseline = '0, amp_a = '0, amp_b = '0, amp_c = '0, pulse_width = '0;
   logic [31:0] delay_ab = '0, delay_bc = '0;
   logic [31:0] adc_data_a, adc_data_b, adc_data_c, adc_data_d;
   logic adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d;
   logic adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d;
   logic busy, done;

   always #5 rxclk = ~rxclk;

   adc_pulse_sim dut (
      .rxclk(rxclk), .rst(rst), .start(start), .baseline(baseline),
      .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c), .pulse_width(pulse_width),
      .delay_ab(delay_ab), .delay_bc(delay_bc),
      .adc_data_a(adc_data_a), .adc_data_b(adc_data_b), .adc_data_c(adc_data_c), .adc_data_d(adc_data_d),
      .adc_valid_a(adc_valid_a), .adc_valid_b(adc_valid_b), .adc_valid_c(adc_valid_c), .adc_valid_d(adc_valid_d),
      .adc_enable_a(adc_enable_a), .adc_enable_b(adc_enable_b), .adc_enable_c(adc_enable_c), .adc_enable_d(adc_enable_d),
      .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [31:0] a, b, c, d;
      logic v, busy, done;
   } exp_t;

   exp_t exp_q[$];
   int n_cmp = 0, n_bad = 0, e = 0, t0 = 0, n_mon = 0;
   bit act = 0;
   logic [15:0] mb, ma, mbb, mc;
   longint w, dab, dbc;

   function automatic logic [15:0] sat(input logic [15:0] x, input logic [15:0] y);
      int s;
      s = int'($signed(x)) + int'($signed(y));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   // Sequence as a timeline: clocks are numbered from 1 after the accepted start
   task automatic model_edge();
      exp_t x;
      bit expired;
      longint p, f;
      x = '0;
      expired = 0;
      if (rst) act = 0;
      else begin
         x.v = 1'b1;
         if (act && (e - t0 + 1) > 3 * w + dab + dbc + 1) begin
            act = 0;
            expired = 1;
         end
         if (!act && !expired && start) begin
            act = 1;
            t0 = e;
            mb = baseline; ma = amp_a; mbb = amp_b; mc = amp_c;
            w = (pulse_width == 0) ? 1 : longint'(pulse_width);
            dab = longint'(delay_ab);
            dbc = longint'(delay_bc);
         end
         if (act) begin
            p = e - t0 + 1;
            f = 3 * w + dab + dbc + 1;
            x.a = (p >= 1 && p <= w) ? {2{sat(mb, ma)}} : {2{mb}};
            x.b = (p >= w + dab + 1 && p <= 2 * w + dab) ? {2{sat(mb, mbb)}} : {2{mb}};
            x.c = (p >= 2 * w + dab + dbc + 1 && p <= f - 1) ? {2{sat(mb, mc)}} : {2{mb}};
            x.d = {2{mb}};
            x.busy = p != f;
            x.done = p == f;
         end else begin
            x.a = {2{baseline}};
            x.b = {2{baseline}};
            x.c = {2{baseline}};
            x.d = {2{baseline}};
         end
      end
      e++;
      exp_q.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at output %0d: got %h want %h", nm, n_mon, got, want);
      end
   endtask

   always @(negedge rxclk) begin : monitor
      exp_t x;
      if (exp_q.size() != 0) begin
         x = exp_q.pop_front();
         chk("data_a", adc_data_a, x.a);
         chk("data_b", adc_data_b, x.b);
         chk("data_c", adc_data_c, x.c);
         chk("data_d", adc_data_d, x.d);
         chk("valid_enable", {24'b0, adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d,
             adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d}, {24'b0, {8{x.v}}});
         chk("busy", 32'(busy), 32'(x.busy));
         chk("done", 32'(done), 32'(x.done));
         n_mon++;
      end
   end

   task automatic tick(input logic s, input logic r);
      start = s;
      rst = r;
      model_edge();
      @(posedge rxclk);
      #1;
      start = 1'b0;
      rst = 1'b0;
   endtask

   task automatic set_p(input logic [15:0] bl, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] pw, input logic [31:0] d1, input logic [31:0] d2);
      baseline = bl; amp_a = a; amp_b = b; amp_c = c;
      pulse_width = pw; delay_ab = d1; delay_bc = d2;
   endtask

   initial begin
      baseline = 16'h0010;
      repeat (3) tick(1'b0, 1'b1);
      repeat (4) tick(1'b0, 1'b0);
      // nominal timing
      set_p(16'd0, 16'd1000, 16'd1000, 16'd1000, 16'd4, 32'd10, 32'd5);
      tick(1'b1, 1'b0);
      repeat (34) tick(1'b0, 1'b0);
      // second start and amp_b change mid-sequence
      tick(1'b1, 1'b0);
      for (int i = 1; i < 34; i++)
         if (i == 6) begin
            amp_b = 16'd77;
            tick(1'b1, 1'b0);
         end else tick(1'b0, 1'b0);
      // saturation at both limits and a non-saturating negative amplitude
      set_p(16'h7F00, 16'h0200, 16'hFF00, 16'h0000, 16'd2, 32'd1, 32'd1);
      tick(1'b1, 1'b0);
      repeat (12) tick(1'b0, 1'b0);
      set_p(16'h8100, 16'h0000, 16'h0000, 16'hFE00, 16'd3, 32'd0, 32'd2);
      tick(1'b1, 1'b0);
      repeat (14) tick(1'b0, 1'b0);
      // zero width and delays, then start in the FINISH clock and right after it
      set_p(16'h1234, 16'h0001, 16'hFFFF, 16'h0100, 16'd0, 32'd0, 32'd0);
      tick(1'b1, 1'b0);
      repeat (3) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      repeat (6) tick(1'b0, 1'b0);
      // reset mid-sequence then replay
      set_p(16'd0, 16'd1000, 16'd1000, 16'd1000, 16'd4, 32'd10, 32'd5);
      tick(1'b1, 1'b0);
      for (int i = 1; i < 12; i++) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      repeat (34) tick(1'b0, 1'b0);
      // randomized sequences with input churn, stray starts and occasional resets
      for (int it = 0; it < 30; it++) begin
         set_p(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom_range(0, 5)), 32'($urandom_range(0, 9)), 32'($urandom_range(0, 9)));
         tick(1'b1, 1'b0);
         for (int i = 0; i < 45; i++) begin
            if ($urandom_range(0, 3) == 0) baseline = 16'($urandom);
            if ($urandom_range(0, 3) == 0) amp_a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) pulse_width = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) delay_ab = 32'($urandom_range(0, 9));
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
         end
      end
      repeat (3) tick(1'b0, 1'b0);
      @(negedge rxclk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_pulse_sim.md
Name: adc_pulse_sim

Overview:
Synthetic ADC stream source that drives the same four-channel, two-samples-per-clock interface that the JESD ADC core presents to the trigger logic.
It generates a programmable sequence of rectangular pulses on channels a, b and c, with cycle-exact gaps between them, on top of a constant baseline.
It substitutes for the JESD ADC outputs in hardware self-test and simulation, so that time-of-flight and delayed-trigger paths can be exercised deterministically.

Parameters:
ADC_DATA_WIDTH, 16, width of one sample; each 32-bit word carries two samples.
CNT_WIDTH, 32, width of the gap and width counters.

Ports:
rxclk  in  1  sample clock (125 MHz); two samples per clock.
rst  in  1  synchronous reset, active-high.
start  in  1  single-cycle request to run one pulse sequence.
baseline  in  16  signed idle sample value.
amp_a  in  16  signed pulse amplitude for channel a (added to baseline).
amp_b  in  16  signed pulse amplitude for channel b.
amp_c  in  16  signed pulse amplitude for channel c.
pulse_width  in  16  pulse length in clocks; 0 is treated as 1.
delay_ab  in  32  idle clocks between the last clock of pulse A and the first clock of pulse B.
delay_bc  in  32  idle clocks between the last clock of pulse B and the first clock of pulse C.
adc_data_a/b/c/d  out  32 each  {sample1[31:16], sample0[15:0]}.
adc_valid_a/b/c/d  out  1 each  data valid.
adc_enable_a/b/c/d  out  1 each  channel enabled.
busy  out  1  sequence in progress.
done  out  1  single-cycle pulse at end of sequence.

Behaviour:
- Clock and reset: rxclk is the only clock. rst is synchronous and active-high.
- Reset values (all outputs registered):
  - adc_data_* = 0
  - adc_valid_* = 0, adc_enable_* = 0
  - busy = 0, done = 0
  - state = IDLE, counters = 0
- Outside reset:
  - adc_valid_* = 1 and adc_enable_* = 1 on every clock.
  - Any channel not currently pulsing outputs {baseline, baseline}.
  - Channel d always outputs baseline.
- Pulse value: both samples in the word equal sat16(baseline + amp_x).
  - The sum is computed at 17 bits signed.
  - Saturate to 16'sh7FFF / 16'sh8000.
- States: IDLE, PULSE_A, GAP_AB, PULSE_B, GAP_BC, PULSE_C, FINISH.
- IDLE:
  - start=1 latches baseline, amp_*, pulse_width, delay_ab and delay_bc.
  - Moves to PULSE_A.
  - The first pulse word appears on adc_data_a the next clock (latency 1 from start).
  - Inputs changed mid-sequence have no effect.
- PULSE_x: lasts exactly max(pulse_width,1) clocks with channel x at pulse value, then moves to the following GAP or to FINISH.
- GAP_AB / GAP_BC:
  - Last exactly delay_ab / delay_bc clocks with all channels at baseline.
  - A delay of 0 skips the GAP state, so the next pulse starts the clock after the previous pulse ends.
- FINISH: one clock. Asserts done=1 and busy=0, outputs baseline, then returns to IDLE.
- busy = 1 in every state except IDLE and FINISH.
- start while busy is ignored. start in the FINISH clock is also ignored.
- rst mid-sequence: next clock shows reset values, state = IDLE; there is no partial completion and no done.
- Counters count down from the latched value. There is no wrap-around: a maximum delay of 2^32-1 runs to completion.
- amp_x = 0 produces a baseline-valued "pulse", but the timing and state sequence are unchanged.

Decomposition:
- Package adc_pulse_sim_pkg:
  - 3-bit state encoding constants.
  - SAMPLE_MAX / SAMPLE_MIN.
  - sat16 add function.
- Sub-module adc_word_sat:
  - Combinational.
  - Inputs: baseline, amp, pulse_en.
  - Output: the 32-bit paired word, either the saturated pulse value or baseline.
  - Instantiated once per channel a/b/c.
- The FSM and counters stay in the top-level module.

Test Plan:
1. Reset then idle: rst high 3 clocks, then low, baseline=16'h0010 → adc_data_* = 0 and valid = 0 during reset; from the first clock after release, adc_data_* = 32'h0010_0010 and valid = enable = 1.
2. Nominal timing: start at cycle 0, pulse_width=4, delay_ab=10, delay_bc=5, amp_a=amp_b=amp_c=16'sd1000, baseline=0 → channel a = 32'h03E8_03E8 on cycles 1–4, channel b on 15–18, channel c on 24–27; done=1 on cycle 28 only; busy=1 on cycles 1–27.
3. Saturation: baseline=16'sh7F00, amp_a=16'sh0200, amp_b=-16'sh0100, baseline/amp_c chosen for the negative limit (baseline=16'sh8100, amp_c=-16'sh0200) → pulse words 32'h7FFF_7FFF and 32'h8000_8000 respectively; channel b shows 32'h7E00_7E00.
4. Zero parameters: pulse_width=0, delay_ab=0, delay_bc=0, start at cycle 0 → a pulses on cycle 1, b on cycle 2, c on cycle 3, done on cycle 4.
5. Ignored start and input change: a second start at cycle 6 of scenario 2, plus amp_b changed at cycle 6 → timing identical to scenario 2, channel b still 1000, exactly one done.
6. Reset mid-sequence: rst at cycle 12 of scenario 2 → cycle 13 shows reset values with busy=0 and no done; a new start after release replays scenario 2 timing.
